// File: rtl/fft_result_reader_if.sv
// Result-memory read port and output stream of fft_result_reader.
// master = the reader; slave = memory plus downstream consumer.
interface fft_result_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output rd_en, rd_addr, m_valid, m_data, m_last,
    input  rd_data, m_ready
  );

  modport slave (
    input  rd_en, rd_addr, m_valid, m_data, m_last,
    output rd_data, m_ready
  );
endinterface

// File: rtl/fft_result_reader.sv
// Streams a finished FFT frame from the result memory through a 2-entry output FIFO.
// Optional macro FFT_RESULT_READER_MAG_EN: emit |re|+|im| instead of the raw complex word.
module fft_result_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                ce,
  input  logic [ADDR_W-1:0]   sample_num,
  input  logic                calc_done,
  fft_result_reader_if.master bus,
  output logic                busy,
  output logic                frame_done,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    DONE   = 2'b10
  } state_e;

  localparam int                H     = DATA_W / 2;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      n_q, n_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_last_q, inflight_last_d;
  logic [1:0][DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic [1:0]             fifo_last_q, fifo_last_d;
  logic [1:0]             cnt_q, cnt_d;

  logic              rd_en, push, pop;
  logic [DATA_W-1:0] wdata;

`ifdef FFT_RESULT_READER_MAG_EN
  localparam logic [H-1:0] ONE_H = 1;
  logic [H-1:0] re_abs, im_abs;
  logic [H:0]   mag;

  // An H-bit unsigned abs holds 2^(H-1) exactly, so the most negative input needs no special case.
  assign re_abs = bus.rd_data[DATA_W-1] ? (~bus.rd_data[DATA_W-1:H] + ONE_H) : bus.rd_data[DATA_W-1:H];
  assign im_abs = bus.rd_data[H-1]      ? (~bus.rd_data[H-1:0] + ONE_H)      : bus.rd_data[H-1:0];
  assign mag    = {1'b0, re_abs} + {1'b0, im_abs};
  assign wdata  = {{(DATA_W-H-1){1'b0}}, mag};
`else
  assign wdata  = bus.rd_data;
`endif

  // Capping occupancy+in-flight at 2 keeps the FIFO lossless without looking at m_ready.
  assign rd_en = (state_q == STREAM) && (addr_q < n_q) &&
                 ((cnt_q + {1'b0, inflight_q}) < 2'd2);
  assign push  = inflight_q;
  assign pop   = (cnt_q != 2'd0) && bus.m_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d         = state_q;
    n_d             = n_q;
    addr_d          = addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    cnt_d           = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (calc_done) begin
          n_d     = sample_num;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = (sample_num == '0) ? DONE : STREAM;
        end
      end

      STREAM: begin
        if (rd_en) addr_d = addr_q + ONE_A;
        inflight_d      = rd_en;
        inflight_last_d = rd_en && (addr_q == n_q - ONE_A);

        unique case ({push, pop})
          2'b11: begin
            if (cnt_q == 2'd2) begin
              fifo_data_d[0] = fifo_data_q[1];
              fifo_last_d[0] = fifo_last_q[1];
              fifo_data_d[1] = wdata;
              fifo_last_d[1] = inflight_last_q;
            end else begin
              fifo_data_d[0] = wdata;
              fifo_last_d[0] = inflight_last_q;
            end
          end
          2'b01: begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_last_d[0] = fifo_last_q[1];
            cnt_d          = cnt_q - 2'd1;
          end
          2'b10: begin
            fifo_data_d[cnt_q[0]] = wdata;
            fifo_last_d[cnt_q[0]] = inflight_last_q;
            cnt_d                 = cnt_q + 2'd1;
          end
          default: ;
        endcase

        if (pop && fifo_last_q[0]) state_d = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= IDLE;
      n_q             <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      // NOTE: FIFO storage is reset too, because m_data must read 0 while in reset.
      fifo_data_q     <= '0;
      fifo_last_q     <= '0;
      cnt_q           <= '0;
    end else if (ce) begin
      // NOTE: state registers use non-blocking assignments so all update together on the edge.
      state_q         <= state_d;
      n_q             <= n_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      cnt_q           <= cnt_d;
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = addr_q;
  assign bus.m_valid = (cnt_q != 2'd0);
  assign bus.m_data  = fifo_data_q[0];
  assign bus.m_last  = fifo_last_q[0] && (cnt_q != 2'd0);
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign state       = state_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Scoreboard bench for fft_result_reader: expected beats are queued at frame start and
// popped by a monitor on every accepted beat. Define FFT_RESULT_READER_MAG_EN for the magnitude test.
module tb_fft_result_reader;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              nrst;
  logic              ce;
  logic              calc_done;
  logic [ADDR_W-1:0] sample_num;
  logic              busy, frame_done;
  logic [1:0]        state;

  fft_result_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fft_result_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .ce         (ce),
    .sample_num (sample_num),
    .calc_done  (calc_done),
    .bus        (bus.master),
    .busy       (busy),
    .frame_done (frame_done),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Result memory: registered read, shares clk and ce
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (ce && bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  beat_t exp_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    beats_seen = 0;
  int    cap_err = 0;
  int    occ_m = 0;
  int    infl_m = 0;
  bit    bp_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int n, input bit do_push = 1'b1);
    sample_num = ADDR_W'(n);
    calc_done  = 1'b1;
    if (do_push)
      for (int i = 0; i < n; i++) exp_q.push_back('{data: mem[i], last: (i == n - 1)});
    tick();
    calc_done = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!frame_done && k < budget) begin
      tick();
      k++;
    end
    check(name, frame_done, 1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Downstream ready: always 1, or the repeating 1,0,0,1 pattern under backpressure
  initial begin
    int cyc = 0;
    logic [3:0] pat = 4'b1001;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = bp_mode ? pat[cyc % 4] : 1'b1;
      cyc++;
    end
  end

  // Monitor: scoreboard compare plus occupancy model for the read-issue cap
  initial begin
    forever begin
      @(negedge clk);
      if (!nrst) begin
        occ_m  = 0;
        infl_m = 0;
      end else begin
        int pop;
        pop = (bus.m_valid && bus.m_ready && ce) ? 1 : 0;
        if (bus.rd_en && (occ_m + infl_m) >= 2) cap_err++;
        if (bus.m_valid !== (occ_m != 0)) cap_err++;
        if (pop == 1) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", bus.m_data, bus.m_last);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", bus.m_data, e.data);
            check("beat_last", bus.m_last, e.last);
          end
        end
        if (ce) begin
          occ_m  = occ_m + infl_m - pop;
          infl_m = bus.rd_en ? 1 : 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, k;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);
    bus.rd_data = '0;
    nrst = 1'b0; ce = 1'b1; calc_done = 1'b0; sample_num = '0;

    // Reset values
    tick(); tick();
    check("reset_state", state, 0);
    check("reset_flags", {busy, frame_done, bus.rd_en, bus.m_valid, bus.m_last}, 0);
    check("reset_addr", bus.rd_addr, 0);
    check("reset_data", bus.m_data, 0);
    nrst = 1'b1;
    tick();

    // Basic frame, N=8
    start(8);
    check("basic_t1_state", state, 1);
    check("basic_t1_rd", {busy, bus.rd_en, bus.rd_addr}, {1'b1, 1'b1, 12'd0});
    tick();
    check("basic_t2_rd", {bus.rd_en, bus.rd_addr, bus.m_valid}, {1'b1, 12'd1, 1'b0});
    tick();
    check("basic_t3_valid", {bus.m_valid, bus.m_data}, {1'b1, 32'd0});
    wait_done("basic_done", 40);
    check("basic_done_busy", busy, 1);
    tick();
    check("basic_idle", {state, busy}, 0);

    // Backpressure, N=16
    bp_mode = 1'b1;
    tick();
    start(16);
    wait_done("bp_done", 200);
    bp_mode = 1'b0;
    check("bp_rd_cap", cap_err, 0);
    tick();

    // Zero-length frame
    start(0);
    check("zero_t1", {state, frame_done, bus.rd_en, bus.m_valid}, {2'd2, 1'b1, 1'b0, 1'b0});
    tick();
    check("zero_t2", {state, frame_done, busy}, 0);
    tick();

    // Clock-enable stall at T+4 plus ignored calc_done in STREAM
    start(8);
    tick(); tick(); tick();
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("stall_ctl", {bus.m_valid, bus.rd_en, state, busy, bus.m_last}, {1'b1, 1'b1, 2'd1, 1'b1, 1'b0});
      check("stall_addr", bus.rd_addr, 2);
      check("stall_data", bus.m_data, 1);
    end
    tick();
    ce = 1'b1;
    sample_num = 12'd3;
    calc_done  = 1'b1;
    tick();
    calc_done  = 1'b0;
    wait_done("stall_done", 60);
    tick(); tick(); tick(); tick();
    check("ignored_start", {state, busy, bus.rd_en}, 0);
    check("stall_rd_cap", cap_err, 0);

    // Async reset at beat 3 of N=8, then N=4
    start(8);
    b0 = beats_seen;
    k  = 0;
    while (beats_seen < b0 + 3 && k < 50) begin
      tick();
      k++;
    end
    check("rst_beats_reached", beats_seen - b0, 3);
    #2;
    nrst = 1'b0;
    #1;
    check("rst_flags", {state, busy, frame_done, bus.rd_en, bus.m_valid, bus.m_last}, 0);
    check("rst_addr", bus.rd_addr, 0);
    check("rst_data", bus.m_data, 0);
    exp_q.delete();
    tick(); tick();
    nrst = 1'b1;
    start(4);
    check("rst_restart", state, 1);
    wait_done("rst_new_done", 40);
    tick();

    // Maximum frame length
    start((1 << ADDR_W) - 1);
    wait_done("max_done", 8000);
    check("max_final_addr", bus.rd_addr, 12'd4095);
    check("max_rd_cap", cap_err, 0);
    tick();

`ifdef FFT_RESULT_READER_MAG_EN
    mem[0] = 32'hFFFD_0005;
    mem[1] = 32'h8000_8000;
    exp_q.push_back('{data: 32'd8, last: 1'b0});
    exp_q.push_back('{data: 32'd65536, last: 1'b1});
    start(2, 1'b0);
    wait_done("mag_done", 40);
    mem[0] = 32'd0;
    mem[1] = 32'd1;
    tick();
`endif

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
